// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use bubbles,
// branch/jump squashing and a freeze while a data-memory access is outstanding.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;

    logic load_use;
    logic start_wait;
    logic timed_out;
    logic freeze;

    always_comb begin
        load_use   = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        start_wait = (state == RUN) && mem_req && !mem_ready;
        timed_out  = (state == MEM_WAIT) && !mem_ready && (wait_cnt == TIMEOUT_V);
        freeze     = start_wait || ((state == MEM_WAIT) && !mem_ready && !timed_out);
    end

    // Release and abort cycles in MEM_WAIT advance the pipeline without
    // evaluating branch/jump/load-use; the held stages re-present them next cycle.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        if (reset) begin
            pc_write = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (state == RUN) begin
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (start_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (timed_out) begin
                        state     <= RUN;
                        wait_cnt  <= '0;
                        mem_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic checked
// against a cycle-level reference model of the controller's rules.
module tb_hazard_ctrl;

    localparam int T  = 4;
    localparam int CW = 3;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic id_uses_rt, id_jump, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
    logic mem_error;
    logic [CW-1:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit m_waiting;
    int m_elapsed;
    bit m_err;
    int m_stall;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    // control vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}
    localparam logic [5:0] C_DEF    = 6'b110101;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_BRANCH = 6'b111111;
    localparam logic [5:0] C_LDUSE  = 6'b000111;
    localparam logic [5:0] C_JUMP   = 6'b111101;

    function automatic logic [5:0] model_ctl();
        bit lu;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (reset) return C_DEF;
        if (m_waiting) begin
            if (!mem_ready && m_elapsed < T) return C_FREEZE;
            return C_DEF;
        end
        if (mem_req && !mem_ready) return C_FREEZE;
        if (ex_branch_taken) return C_BRANCH;
        if (lu) return C_LDUSE;
        if (id_jump) return C_JUMP;
        return C_DEF;
    endfunction

    task automatic model_clock(input logic [5:0] ctl);
        if (!m_waiting) begin
            if (mem_req && !mem_ready) begin
                m_waiting = 1;
                m_elapsed = 1;
            end
        end else if (mem_ready) begin
            m_waiting = 0;
        end else if (m_elapsed < T) begin
            m_elapsed++;
        end else begin
            m_waiting = 0;
            m_err = 1;
        end
        if (!ctl[5]) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
    endtask

    task automatic model_reset();
        m_waiting = 0;
        m_elapsed = 0;
        m_err = 0;
        m_stall = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] dut_ctl();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write};
    endfunction

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; id_jump = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(input string tag, input bit use_want, input logic [5:0] want);
        logic [5:0] e;
        e = model_ctl();
        #1;
        chk({tag, "_ctl"}, 16'(dut_ctl()), 16'(e));
        if (use_want) chk({tag, "_ctl_spec"}, 16'(dut_ctl()), 16'(want));
        @(posedge clk);
        model_clock(e);
        #1;
        chk({tag, "_stall"}, 16'(stall_cycles), 16'(m_stall));
        chk({tag, "_err"}, 16'(mem_error), 16'(m_err));
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        #3;
        chk("reset_ctl", 16'(dut_ctl()), 16'(C_DEF));
        chk("reset_stall", 16'(stall_cycles), 16'd0);
        chk("reset_err", 16'(mem_error), 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();

        // load-use then release, then $0 never stalls
        ex_mem_read = 1; ex_rt = 8; id_rs = 8;
        cycle("lduse", 1, C_LDUSE);
        idle_inputs();
        cycle("lduse_clear", 1, C_DEF);
        chk("lduse_count", 16'(stall_cycles), 16'd1);
        ex_mem_read = 1; ex_rt = 0; id_rs = 0;
        cycle("reg0", 1, C_DEF);

        // branch beats load-use on rt; jump alone flushes IF/ID only
        idle_inputs();
        ex_branch_taken = 1; ex_mem_read = 1; ex_rt = 9; id_rt = 9; id_uses_rt = 1;
        cycle("branch_lu", 1, C_BRANCH);
        chk("branch_count", 16'(stall_cycles), 16'd1);
        idle_inputs();
        id_jump = 1;
        cycle("jump", 1, C_JUMP);
        id_jump = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3;
        cycle("lu_over_jump", 1, C_LDUSE);
        ex_mem_read = 0;
        cycle("jump_retry", 1, C_JUMP);

        // memory wait 3 cycles with a branch during the wait, then release
        idle_inputs();
        mem_req = 1;
        cycle("mw1", 1, C_FREEZE);
        ex_branch_taken = 1;
        cycle("mw2", 1, C_FREEZE);
        cycle("mw3", 1, C_FREEZE);
        mem_ready = 1;
        cycle("mw_release", 1, C_DEF);
        chk("mw_count", 16'(stall_cycles), 16'd5);
        mem_req = 0; mem_ready = 0;
        cycle("mw_branch_after", 1, C_BRANCH);

        // timeout: frozen for T cycles, abort in cycle T+1, sticky error
        idle_inputs();
        mem_req = 1;
        for (int i = 1; i <= T; i++) cycle("to_freeze", 1, C_FREEZE);
        cycle("to_abort", 1, C_DEF);
        chk("to_err", 16'(mem_error), 16'd1);
        chk("to_sat", 16'(stall_cycles), 16'(SAT));
        idle_inputs();
        id_jump = 1;
        cycle("to_after1", 1, C_JUMP);
        id_jump = 0;
        cycle("to_after2", 1, C_DEF);
        chk("to_sticky", 16'(mem_error), 16'd1);

        // asynchronous reset in the second wait cycle
        mem_req = 1;
        cycle("rw1", 1, C_FREEZE);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rw_ctl", 16'(dut_ctl()), 16'(C_DEF));
        chk("rw_stall", 16'(stall_cycles), 16'd0);
        chk("rw_err", 16'(mem_error), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_req = 0; mem_ready = 1;
        cycle("rw_after", 1, C_DEF);

        // saturation: 10 consecutive load-use stalls
        idle_inputs();
        ex_mem_read = 1; ex_rt = 5; id_rt = 5; id_uses_rt = 1;
        for (int i = 0; i < 10; i++) cycle("sat", 1, C_LDUSE);
        chk("sat_hold", 16'(stall_cycles), 16'(SAT));

        // random traffic against the model
        idle_inputs();
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_jump         = ($urandom_range(0, 7) == 0);
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_req         = ($urandom_range(0, 5) == 0);
            mem_ready       = ($urandom_range(0, 3) == 0);
            cycle("rand", 0, C_DEF);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
